mac_dot_unit: RTL

Sequential dot-product engine that sits directly upstream of result consumers and wraps the team's 8x8 combinational multiplier `wallace`. It accepts a stream of unsigned 8-bit operand pairs over a valid/ready handshake and registers each pair before the multiplier. It registers the 16-bit product after the multiplier and accumulates DOT_LEN products. It then presents the sum on a held valid/ready output.

---
 rtl/mac_pkg.sv | 14 +
 rtl/wallace.sv | 35 +++
 rtl/mac_dot_unit.sv | 118 +++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared types and constants for the mac_dot_unit dot-product engine.
package mac_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DOT_LEN_DEF = 8;
  localparam int ACC_W_DEF   = 24;
  localparam int PROD_W      = 16;

endpackage

// File: rtl/wallace.sv
// 8x8 unsigned combinational multiplier: partial products reduced by a chain
// of 3:2 carry-save stages, then one carry-propagate add.
module wallace
  import mac_pkg::*;
(
  input  logic [7:0]        a,
  input  logic [7:0]        b,
  output logic [PROD_W-1:0] m
);

  logic [PROD_W-1:0] pp [8];
  logic [PROD_W-1:0] s;
  logic [PROD_W-1:0] c;
  logic [PROD_W-1:0] t;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      pp[i] = b[i] ? (PROD_W'(a) << i) : '0;
    end
  end

  // s + c always equals the sum of the rows folded in so far.
  always_comb begin
    s = pp[0];
    c = '0;
    t = '0;
    for (int i = 1; i < 8; i++) begin
      t = s ^ c ^ pp[i];
      c = ((s & c) | (s & pp[i]) | (c & pp[i])) << 1;
      s = t;
    end
    m = s + c;
  end

endmodule

// File: rtl/mac_dot_unit.sv
// Sequential dot-product engine: two-stage multiply pipeline feeding an
// accumulator, with a three-state control FSM and a held result output.
module mac_dot_unit
  import mac_pkg::*;
#(
  parameter int DOT_LEN = DOT_LEN_DEF,
  parameter int ACC_W   = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = $clog2(DOT_LEN + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DOT_LEN - 1);

  // Handshakes: a transfer happens at a rising edge where valid & ready are
  // both 1. in_ready depends on state only; out_valid is a register that,
  // once set, holds with stable out_acc until out_ready is seen.
  state_e            state;
  logic [7:0]        a_q;
  logic [7:0]        b_q;
  logic              v1;
  logic              v2;
  logic [PROD_W-1:0] m;
  logic [PROD_W-1:0] p_q;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  acc_cnt;
  logic              out_valid_q;
  logic              accept;

  assign in_ready  = (state == ACCUM);
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign out_acc   = acc;
  assign busy      = (state != ACCUM) | (issue_cnt != '0);
  assign dbg_state = state;

  wallace u_wallace (
    .a (a_q),
    .b (b_q),
    .m (m)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      v1  <= 1'b0;
      p_q <= '0;
      v2  <= 1'b0;
    end else begin
      v1 <= accept;
      if (accept) begin
        a_q <= in_a;
        b_q <= in_b;
      end
      v2 <= v1;
      if (v1) begin
        p_q <= m;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ACCUM;
      issue_cnt   <= '0;
      acc_cnt     <= '0;
      acc         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (v2) begin
        acc     <= acc + ACC_W'(p_q);
        acc_cnt <= acc_cnt + CNT_W'(1);
      end
      case (state)
        ACCUM: begin
          if (accept) begin
            issue_cnt <= issue_cnt + CNT_W'(1);
            if (issue_cnt == LAST) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // The final product lands in acc on this same edge.
          if (v2 && (acc_cnt == LAST)) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state       <= ACCUM;
            out_valid_q <= 1'b0;
            acc         <= '0;
            issue_cnt   <= '0;
            acc_cnt     <= '0;
          end
        end
        default: begin
          state <= ACCUM;
        end
      endcase
    end
  end

endmodule
